// File: rtl/alu_arbiter.sv
// Round-robin arbiter that time-shares one Hack-style ALU between N_REQ requesters
// and returns each result on a single ID-tagged response channel.
module alu_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 16,
    parameter int ID_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*WIDTH-1:0]   req_x,
    input  logic [N_REQ*WIDTH-1:0]   req_y,
    input  logic [N_REQ*6-1:0]       req_op,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_out,
    output logic                     resp_zr,
    output logic                     resp_ng
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_last_grant;
    logic [ID_W-1:0]  r_gid;
    logic [ID_W-1:0]  r_id;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [5:0]       r_op;
    logic [WIDTH-1:0] r_out;
    logic             r_zr;
    logic             r_ng;

    logic [WIDTH-1:0] w_x [N_REQ];
    logic [WIDTH-1:0] w_y [N_REQ];
    logic [5:0]       w_op [N_REQ];
    logic             w_found;
    logic [ID_W-1:0]  w_grant;
    logic [ID_W:0]    w_idx;
    logic [ID_W-1:0]  w_sel;
    logic [WIDTH-1:0] w_x1, w_x2, w_y1, w_y2, w_o1, w_alu;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign w_x[gi]  = req_x[gi*WIDTH +: WIDTH];
            assign w_y[gi]  = req_y[gi*WIDTH +: WIDTH];
            assign w_op[gi] = req_op[gi*6 +: 6];
            // Gated by rst_n so no requester sees ready while reset is held.
            assign req_ready[gi] = rst_n && (r_state == IDLE) && w_found
                                   && (w_grant == ID_W'(gi));
        end
    endgenerate

    // Scan from the requester after the last winner, wrapping modulo N_REQ.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        w_sel   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = {1'b0, r_last_grant} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(N_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(N_REQ);
            end
            w_sel = w_idx[ID_W-1:0];
            if (!w_found && req_valid[w_sel]) begin
                w_found = 1'b1;
                w_grant = w_sel;
            end
        end
    end

    // Control word bits: [5]=zx [4]=nx [3]=zy [2]=ny [1]=f [0]=no.
    always_comb begin
        w_x1  = r_op[5] ? '0 : r_x;
        w_x2  = r_op[4] ? ~w_x1 : w_x1;
        w_y1  = r_op[3] ? '0 : r_y;
        w_y2  = r_op[2] ? ~w_y1 : w_y1;
        w_o1  = r_op[1] ? (w_x2 + w_y2) : (w_x2 & w_y2);
        w_alu = r_op[0] ? ~w_o1 : w_o1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= ID_W'(N_REQ-1);
            r_gid        <= '0;
            r_id         <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_op         <= '0;
            r_out        <= '0;
            r_zr         <= 1'b0;
            r_ng         <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_x          <= w_x[w_grant];
                        r_y          <= w_y[w_grant];
                        r_op         <= w_op[w_grant];
                        r_gid        <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_out   <= w_alu;
                    r_zr    <= (w_alu == '0);
                    r_ng    <= w_alu[WIDTH-1];
                    r_id    <= r_gid;
                    r_state <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign resp_valid = (r_state == RESP);
    assign resp_id    = r_id;
    assign resp_out   = r_out;
    assign resp_zr    = r_zr;
    assign resp_ng    = r_ng;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter: reset, ALU functions,
// round-robin order, response backpressure and reset during execution.
module tb_alu_arbiter;

    localparam int N_REQ = 4;
    localparam int WIDTH = 16;
    localparam int ID_W  = 2;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_x;
    logic [N_REQ*WIDTH-1:0] req_y;
    logic [N_REQ*6-1:0]     req_op;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [ID_W-1:0]        resp_id;
    logic [WIDTH-1:0]       resp_out;
    logic                   resp_zr;
    logic                   resp_ng;

    int n_checks;
    int n_fail;

    alu_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ID_W(ID_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_out   (resp_out),
        .resp_zr    (resp_zr),
        .resp_ng    (resp_ng)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [15:0] x, input logic [15:0] y,
                           input logic [5:0] op);
        req_x[id*WIDTH +: WIDTH] = x;
        req_y[id*WIDTH +: WIDTH] = y;
        req_op[id*6 +: 6]        = op;
    endtask

    // One complete request/response exchange with resp_ready held high.
    task automatic run_op(input string tag, input int id, input logic [15:0] x,
                          input logic [15:0] y, input logic [5:0] op,
                          input logic [15:0] e_out, input logic e_zr, input logic e_ng);
        int n;
        set_req(id, x, y, op);
        req_valid  = 4'b0001 << id;
        resp_ready = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 10) begin step(); n++; end
        chk({tag, "_ready"}, req_ready, 4'b0001 << id);
        step();
        req_valid = '0;
        #1;
        n = 0;
        while (!resp_valid && n < 10) begin step(); n++; end
        chk({tag, "_valid"}, resp_valid, 1);
        chk({tag, "_out"}, resp_out, e_out);
        chk({tag, "_zr"}, resp_zr, e_zr);
        chk({tag, "_ng"}, resp_ng, e_ng);
        chk({tag, "_id"}, resp_id, id);
        $display("txn %s id=%0d out=%h zr=%0b ng=%0b", tag, resp_id, resp_out, resp_zr, resp_ng);
        step();
        chk({tag, "_done"}, resp_valid, 0);
    endtask

    logic [15:0] rr_x [N_REQ];
    int          rr_order [6];

    initial begin
        int n;
        n_checks   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        req_op     = '0;
        resp_ready = 1'b0;
        rr_order   = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < N_REQ; i++) rr_x[i] = 16'(16'h1000 * (i + 1) + i);

        // Reset values, even with every requester asking
        req_valid = 4'hF;
        step();
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_id", resp_id, 0);
        chk("rst_out", resp_out, 0);
        chk("rst_zr", resp_zr, 0);
        chk("rst_ng", resp_ng, 0);
        req_valid = '0;
        step();
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_ready", req_ready, 0);
            chk("idle_valid", resp_valid, 0);
            chk("idle_out", resp_out, 0);
        end

        // Single op with latency check: requester 1, x - y
        set_req(1, 16'd5, 16'd3, 6'b010011);
        req_valid  = 4'b0010;
        resp_ready = 1'b1;
        #1;
        chk("single_ready", req_ready, 4'b0010);
        step();
        req_valid = '0;
        #1;
        chk("single_lat1", resp_valid, 0);
        step();
        chk("single_lat2", resp_valid, 1);
        chk("single_out", resp_out, 16'd2);
        chk("single_id", resp_id, 1);
        chk("single_zr", resp_zr, 0);
        chk("single_ng", resp_ng, 0);
        $display("txn single id=%0d out=%h zr=%0b ng=%0b", resp_id, resp_out, resp_zr, resp_ng);
        step();
        chk("single_done", resp_valid, 0);

        // Function coverage on requester 0
        run_op("add",   0, 16'h00F0, 16'h0F0F, 6'b000010, 16'h0FFF, 1'b0, 1'b0);
        run_op("and",   0, 16'h00F0, 16'h0F0F, 6'b000000, 16'h0000, 1'b1, 1'b0);
        run_op("neg1",  0, 16'h00F0, 16'h0F0F, 6'b111010, 16'hFFFF, 1'b0, 1'b1);
        run_op("wrap",  0, 16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0);
        // Pass-through of x on requester 3; also leaves requester 0 first in line
        run_op("passx", 3, 16'h8001, 16'h5555, 6'b001100, 16'h8001, 1'b0, 1'b1);

        // Round-robin with all requesters continuously valid
        for (int i = 0; i < N_REQ; i++) set_req(i, rr_x[i], 16'h0000, 6'b001100);
        req_valid  = 4'hF;
        resp_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (req_ready == 0 && n < 10) begin step(); n++; end
            chk("rr_grant", req_ready, 4'b0001 << rr_order[k]);
            step();
            n = 0;
            while (!resp_valid && n < 10) begin step(); n++; end
            chk("rr_id", resp_id, rr_order[k]);
            chk("rr_out", resp_out, rr_x[rr_order[k]]);
            $display("txn rr%0d id=%0d out=%h", k, resp_id, resp_out);
            step();
        end
        req_valid = '0;

        // Backpressure: requester 0 result held while requester 2 waits
        resp_ready = 1'b0;
        set_req(0, 16'h00F0, 16'h0F0F, 6'b000010);
        req_valid = 4'b0001;
        #1;
        chk("bp_grant0", req_ready, 4'b0001);
        step();
        set_req(2, 16'h1234, 16'h0000, 6'b001100);
        req_valid = 4'b0100;
        #1;
        chk("bp_exec_ready", req_ready, 0);
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", resp_valid, 1);
            chk("bp_out", resp_out, 16'h0FFF);
            chk("bp_id", resp_id, 0);
            chk("bp_ready", req_ready, 0);
            step();
        end
        $display("txn bp id=%0d out=%h", resp_id, resp_out);
        resp_ready = 1'b1;
        #1;
        chk("bp_hs_ready", req_ready, 0);
        step();
        chk("bp_grant2", req_ready, 4'b0100);
        step();
        req_valid = '0;
        step();
        chk("bp2_valid", resp_valid, 1);
        chk("bp2_id", resp_id, 2);
        chk("bp2_out", resp_out, 16'h1234);
        $display("txn bp2 id=%0d out=%h", resp_id, resp_out);
        step();

        // Reset while in EXEC drops the operation
        set_req(1, 16'h0007, 16'h0001, 6'b000010);
        req_valid = 4'b0010;
        #1;
        chk("mr_grant", req_ready, 4'b0010);
        step();
        req_valid = '0;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", resp_valid, 0);
        chk("mr_out", resp_out, 0);
        chk("mr_id", resp_id, 0);
        for (int i = 0; i < N_REQ; i++) set_req(i, rr_x[i], 16'h0000, 6'b001100);
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mr_hold_valid", resp_valid, 0);
            chk("mr_hold_ready", req_ready, 0);
        end
        rst_n = 1'b1;
        #1;
        chk("mr_tie", req_ready, 4'b0001);
        step();
        req_valid = '0;
        step();
        chk("mr_resp_valid", resp_valid, 1);
        chk("mr_resp_id", resp_id, 0);
        chk("mr_resp_out", resp_out, rr_x[0]);
        $display("txn mr id=%0d out=%h", resp_id, resp_out);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
